// File: rtl/fpga_clk_ratio_gen.sv
// APB-programmable multi-channel clock-enable generator.
// Each channel emits a one-cycle clk_en pulse every (ratio+1) cycles. New
// ratios are held in a shadow register and only become active at a period
// boundary, so no channel ever produces a short or stretched period.
module fpga_clk_ratio_gen #(
  parameter int                NUM_CH  = 4,
  parameter int                RATIO_W = 3,
  parameter logic [NUM_CH-1:0] RST_EN  = {NUM_CH{1'b1}}
) (
  input  logic                        i_pad_clk,
  input  logic                        clkrst,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [7:0]                  paddr,
  input  logic [31:0]                 pwdata,
  output logic [31:0]                 prdata,
  output logic                        pready,
  output logic                        pslverr,
  output logic [NUM_CH-1:0]           clk_en,
  output logic [NUM_CH*RATIO_W-1:0]   pad_biu_clkratio
);

  localparam logic [5:0] CTRL_WORD = 6'h10;
  localparam logic [5:0] STAT_WORD = 6'h11;

  logic [RATIO_W-1:0] shadow_q [NUM_CH];
  logic [RATIO_W-1:0] shadow_d [NUM_CH];
  logic [RATIO_W-1:0] active_q [NUM_CH];
  logic [RATIO_W-1:0] active_d [NUM_CH];
  logic [RATIO_W-1:0] cnt_q    [NUM_CH];
  logic [RATIO_W-1:0] cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  ctrl_q, ctrl_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               pslverr_q, pslverr_d;

  logic [5:0]  word;
  logic        ratio_hit, ctrl_hit, stat_hit, unmapped;
  logic        apb_wr, setup_rd;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign word      = paddr[7:2];
  assign ratio_hit = (word < 6'(NUM_CH));
  assign ctrl_hit  = (word == CTRL_WORD);
  assign stat_hit  = (word == STAT_WORD);
  assign unmapped  = ~(ratio_hit | ctrl_hit | stat_hit);
  assign apb_wr    = psel & penable & pwrite & ~unmapped;
  assign setup_rd  = psel & ~penable & ~pwrite;

  // byte-lane bits of the address and high write-data bits carry no meaning
  assign unused_bits = ^{paddr[1:0], pwdata};

  assign pready  = 1'b1;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

  // Register read mux; unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    if (ctrl_hit) begin
      rd_data[NUM_CH-1:0] = ctrl_q;
    end else if (stat_hit) begin
      rd_data[NUM_CH-1:0] = pending_q;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (word == 6'(n)) rd_data[RATIO_W-1:0] = shadow_q[n];
      end
    end
  end

  // Next state for the register file and every channel's counter/ratio pair.
  always_comb begin
    ctrl_d = ctrl_q;
    if (apb_wr && ctrl_hit) ctrl_d = pwdata[NUM_CH-1:0];
    prdata_d  = setup_rd ? rd_data : prdata_q;
    // registered at setup so the flag is up exactly during the access phase
    pslverr_d = psel & ~penable & unmapped;
    pending_d = pending_q;
    for (int n = 0; n < NUM_CH; n++) begin
      shadow_d[n] = shadow_q[n];
      active_d[n] = active_q[n];
      cnt_d[n]    = cnt_q[n];
      if (ctrl_q[n]) begin
        if (cnt_q[n] == active_q[n]) begin
          cnt_d[n] = '0;
          if (pending_q[n]) begin
            active_d[n]  = shadow_q[n];
            pending_d[n] = 1'b0;
          end
        end else begin
          cnt_d[n] = cnt_q[n] + RATIO_W'(1);
        end
      end else begin
        // idle channel tracks the shadow so it restarts on the newest ratio
        cnt_d[n]     = '0;
        active_d[n]  = shadow_q[n];
        pending_d[n] = 1'b0;
      end
      // a write outranks the terminal-cycle clear, keeping the new value queued
      if (apb_wr && word == 6'(n)) begin
        shadow_d[n]  = pwdata[RATIO_W-1:0];
        pending_d[n] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_pad_clk) begin
    if (clkrst) begin
      ctrl_q    <= RST_EN;
      pending_q <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_q[n] <= '0;
        active_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
    end else begin
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_q[n] <= shadow_d[n];
        active_q[n] <= active_d[n];
        cnt_q[n]    <= cnt_d[n];
      end
    end
  end

  // Enable pulses and the packed active-ratio bus, straight from flops.
  always_comb begin
    clk_en           = '0;
    pad_biu_clkratio = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      clk_en[n] = ctrl_q[n] & (cnt_q[n] == active_q[n]);
      pad_biu_clkratio[n*RATIO_W +: RATIO_W] = active_q[n];
    end
  end

endmodule

// File: tb/tb_fpga_clk_ratio_gen.sv
// Bench for fpga_clk_ratio_gen: register table, directed period sequences
// and randomized APB traffic against a timestamp-based channel model.
module tb_fpga_clk_ratio_gen;
  localparam int NUM_CH  = 4;
  localparam int RATIO_W = 3;

  logic                      i_pad_clk = 1'b0;
  logic                      clkrst = 1'b1;
  logic                      psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]                paddr = '0;
  logic [31:0]               pwdata = '0;
  logic [31:0]               prdata;
  logic                      pready, pslverr;
  logic [NUM_CH-1:0]         clk_en;
  logic [NUM_CH*RATIO_W-1:0] pad_biu_clkratio;

  fpga_clk_ratio_gen #(.NUM_CH(NUM_CH), .RATIO_W(RATIO_W)) dut (
    .i_pad_clk(i_pad_clk), .clkrst(clkrst), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .clk_en(clk_en),
    .pad_biu_clkratio(pad_biu_clkratio)
  );

  always #5 i_pad_clk = ~i_pad_clk;

  int total = 0, bad = 0;
  int cyc = 0;

  // reference model: enable, shadow, active, pending, absolute time of next pulse
  bit                 m_en   [NUM_CH];
  logic [RATIO_W-1:0] m_sh   [NUM_CH];
  logic [RATIO_W-1:0] m_act  [NUM_CH];
  bit                 m_pend [NUM_CH];
  int                 m_next [NUM_CH];
  logic [31:0]        exp_rd;
  bit                 exp_err;

  int mon_ch = 0;
  int last_pulse = -1;
  int gaps[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  function automatic bit m_unmapped(input logic [7:0] a);
    int w = int'(a[7:2]);
    return !(w < NUM_CH || w == 16 || w == 17);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int w = int'(a[7:2]);
    logic [31:0] r = '0;
    if (w < NUM_CH) r = 32'(m_sh[w]);
    else if (w == 16) for (int n = 0; n < NUM_CH; n++) r[n] = m_en[n];
    else if (w == 17) for (int n = 0; n < NUM_CH; n++) r[n] = m_pend[n];
    return r;
  endfunction

  task automatic model_reset(input int first_cycle);
    for (int n = 0; n < NUM_CH; n++) begin
      m_en[n] = 1'b1; m_sh[n] = '0; m_act[n] = '0; m_pend[n] = 1'b0;
      m_next[n] = first_cycle;
    end
    exp_rd = '0; exp_err = 1'b0;
  endtask

  function automatic int gap_at(input int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  // One clock: check outputs, drive inputs, advance the model, wait the edge.
  task automatic step(input bit rst, input bit s, input bit e, input bit w,
                      input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit err);
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH*RATIO_W-1:0] bus;
    for (int n = 0; n < NUM_CH; n++) begin
      ce[n] = m_en[n] && (cyc == m_next[n]);
      bus[n*RATIO_W +: RATIO_W] = m_act[n];
    end
    check("clk_en", 32'(clk_en), 32'(ce));
    check("ratio_bus", 32'(pad_biu_clkratio), 32'(bus));
    if (clk_en[mon_ch]) begin
      if (last_pulse >= 0) gaps.push_back(cyc - last_pulse);
      last_pulse = cyc;
    end
    clkrst = rst; psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    if (s && !e) begin
      exp_err = m_unmapped(a);
      if (!w) exp_rd = exp_err ? 32'h0 : m_read(a);
    end
    #1;
    rd = prdata; err = pslverr;
    if (s && e) begin
      check("pslverr", 32'(pslverr), 32'(exp_err));
      if (!w) check("prdata", prdata, exp_rd);
    end
    if (rst) begin
      model_reset(cyc + 1);
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (m_en[n]) begin
          if (cyc == m_next[n]) begin
            if (m_pend[n]) begin m_act[n] = m_sh[n]; m_pend[n] = 1'b0; end
            m_next[n] = cyc + 1 + int'(m_act[n]);
          end
        end else begin
          m_act[n] = m_sh[n]; m_pend[n] = 1'b0;
          m_next[n] = cyc + 1 + int'(m_act[n]);
        end
      end
      if (s && e && w) begin
        int wd = int'(a[7:2]);
        if (wd < NUM_CH) begin m_sh[wd] = d[RATIO_W-1:0]; m_pend[wd] = 1'b1; end
        else if (wd == 16) for (int n = 0; n < NUM_CH; n++) m_en[n] = d[n];
      end
    end
    cyc++;
    @(posedge i_pad_clk); #1;
  endtask

  task automatic idle(input int k);
    logic [31:0] rd; bit err;
    repeat (k) step(0, 0, 0, 0, 8'h0, 32'h0, rd, err);
  endtask

  task automatic do_reset();
    logic [31:0] rd; bit err;
    step(1, 0, 0, 0, 8'h0, 32'h0, rd, err);
  endtask

  task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit err);
    step(0, 1, 0, w, a, d, rd, err);
    step(0, 1, 1, w, a, d, rd, err);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd; bit err;
    apb(1, a, d, rd, err);
  endtask

  task automatic wait_pulse(input int ch);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (clk_en[ch]) found = 1;
      else idle(1);
    end
    check("pulse_seen", 32'(found), 32'd1);
  endtask

  task automatic mon(input int ch);
    mon_ch = ch; last_pulse = -1; gaps.delete();
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #500000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit err;
    logic [7:0] addrs [8];

    tbl[0]  = '{0, 8'h40, 32'h0,        32'hF, 0};
    tbl[1]  = '{0, 8'h44, 32'h0,        32'h0, 0};
    tbl[2]  = '{0, 8'h04, 32'h0,        32'h0, 0};
    tbl[3]  = '{1, 8'h20, 32'h7,        32'h0, 1};
    tbl[4]  = '{0, 8'h20, 32'h0,        32'h0, 1};
    tbl[5]  = '{0, 8'h04, 32'h0,        32'h0, 0};
    tbl[6]  = '{1, 8'h44, 32'hFF,       32'h0, 0};
    tbl[7]  = '{0, 8'h44, 32'h0,        32'h0, 0};
    tbl[8]  = '{1, 8'h00, 32'hFFFFFFFA, 32'h0, 0};
    tbl[9]  = '{0, 8'h44, 32'h0,        32'h1, 0};
    tbl[10] = '{0, 8'h44, 32'h0,        32'h0, 0};
    tbl[11] = '{0, 8'h00, 32'h0,        32'h2, 0};
    tbl[12] = '{0, 8'h03, 32'h0,        32'h2, 0};
    tbl[13] = '{0, 8'h7C, 32'h0,        32'h0, 1};
    tbl[14] = '{0, 8'h40, 32'h0,        32'hF, 0};

    @(posedge i_pad_clk); #1;
    cyc = 0;
    model_reset(0);
    check("rst_clk_en", 32'(clk_en), 32'hF);
    check("rst_ratio", 32'(pad_biu_clkratio), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);

    // register map table
    for (int i = 0; i < 15; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err);
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      if (!tbl[i].wr) check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
    end

    // ratio 3 on channel 1: status visible before load, then period 4
    do_reset();
    wr(8'h04, 32'h3);
    apb(0, 8'h44, 32'h0, rd, err);
    check("a_status", rd, 32'h2);
    mon(1);
    idle(16);
    check("a_gap0", 32'(gap_at(0)), 32'd4);
    check("a_gap1", 32'(gap_at(1)), 32'd4);
    check("a_gap2", 32'(gap_at(2)), 32'd4);
    check("a_ratio1", 32'(pad_biu_clkratio[5:3]), 32'd3);

    // channel 2: ratio 5, rewrite to 1 mid-period
    do_reset();
    wr(8'h08, 32'h5);
    idle(3);
    mon(2);
    wait_pulse(2);
    idle(2);
    wr(8'h08, 32'h1);
    idle(12);
    check("b_gap0", 32'(gap_at(0)), 32'd6);
    check("b_gap1", 32'(gap_at(1)), 32'd2);
    check("b_gap2", 32'(gap_at(2)), 32'd2);
    foreach (gaps[i]) check("b_gap_range", 32'(gaps[i] >= 2 && gaps[i] <= 6), 32'd1);

    // channel 0: write on the terminal cycle, then back-to-back writes
    do_reset();
    wr(8'h00, 32'h2);
    idle(3);
    mon(0);
    wait_pulse(0);
    idle(2);
    wr(8'h00, 32'h7);
    idle(22);
    check("c_gap0", 32'(gap_at(0)), 32'd3);
    check("c_gap1", 32'(gap_at(1)), 32'd3);
    check("c_gap2", 32'(gap_at(2)), 32'd8);
    check("c_gap3", 32'(gap_at(3)), 32'd8);
    mon(0);
    wait_pulse(0);
    wr(8'h00, 32'h4);
    wr(8'h00, 32'h6);
    idle(24);
    check("c_gap4", 32'(gap_at(0)), 32'd8);
    check("c_gap5", 32'(gap_at(1)), 32'd7);
    check("c_gap6", 32'(gap_at(2)), 32'd7);
    foreach (gaps[i]) check("c_no_ratio4", 32'(gaps[i] == 5), 32'd0);

    // disable channels 1 and 3, reprogram 3 while idle, re-enable
    do_reset();
    wr(8'h40, 32'h5);
    idle(2);
    check("d_off", 32'(clk_en & 4'b1010), 32'h0);
    wr(8'h0C, 32'h2);
    check("d_act3_hold", 32'(pad_biu_clkratio[11:9]), 32'd0);
    idle(1);
    check("d_act3_load", 32'(pad_biu_clkratio[11:9]), 32'd2);
    wr(8'h40, 32'hF);
    check("d_re0", 32'(clk_en[3]), 32'd0);
    idle(1);
    check("d_re1", 32'(clk_en[3]), 32'd0);
    idle(1);
    check("d_re2", 32'(clk_en[3]), 32'd1);

    // reset mid-period
    wr(8'h00, 32'h5);
    wr(8'h08, 32'h3);
    idle(4);
    do_reset();
    check("e_clk_en", 32'(clk_en), 32'hF);
    check("e_ratio", 32'(pad_biu_clkratio), 32'h0);
    apb(0, 8'h00, 32'h0, rd, err);
    check("e_shadow0", rd, 32'h0);
    apb(0, 8'h40, 32'h0, rd, err);
    check("e_ctrl", rd, 32'hF);

    // randomized traffic checked every cycle against the model
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'h20, 8'h7C};
    for (int it = 0; it < 250; it++) begin
      int op;
      idle($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        wr(8'(4 * $urandom_range(0, NUM_CH - 1)), $urandom);
      end else if (op == 5) begin
        wr(8'h40, ($urandom_range(0, 3) == 0) ? $urandom : 32'hF);
      end else if (op <= 8) begin
        logic [7:0] a;
        a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 7)];
        apb(0, a, 32'h0, rd, err);
      end else if ($urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        wr(8'($urandom), $urandom);
      end
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_clk_ratio_gen.md
Name: fpga_clk_ratio_gen

Overview:
- Parametrised, APB-programmable, multi-channel clock-enable generator for the FPGA smart_run clock tree.
- Successor to the single fixed-enable clock-ratio register block.
- Each channel has a programmable divide ratio and an enable bit, and produces a one-cycle clk_en pulse every (ratio+1) cycles of i_pad_clk.
- Ratio changes are shadowed and applied only at a period boundary, so no channel ever sees a short or long enable period.

Parameters:
- NUM_CH, 4, number of clock-enable channels (1..8).
- RATIO_W, 3, width of each channel's ratio field (1..16).
- RST_EN, {NUM_CH{1'b1}}, reset value of the channel-enable register.

Ports:
- i_pad_clk  input  1  single clock; all logic on posedge.
- clkrst  input  1  synchronous, active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  APB write.
- paddr  input  8  APB byte address; bits [1:0] ignored.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data, registered.
- pready  output  1  tied 1 (zero wait states).
- pslverr  output  1  error response for an unmapped address.
- clk_en  output  NUM_CH  per-channel enable pulse.
- pad_biu_clkratio  output  NUM_CH*RATIO_W  active ratio of every channel; channel n occupies bits [n*RATIO_W +: RATIO_W].

Behaviour:
- Interface: one clock (i_pad_clk); reset clkrst is synchronous and active-high. Every flop resets on a posedge of i_pad_clk while clkrst=1.
- Register map (word offsets):
  - 0x00+4n: RATIO[n], for n < NUM_CH. Read returns the shadow ratio in [RATIO_W-1:0], zeros above.
  - 0x40: CTRL, enables in [NUM_CH-1:0].
  - 0x44: STATUS, read-only, pending bits in [NUM_CH-1:0].
  - Writes to STATUS are ignored without error.
- Write: takes effect when psel&penable&pwrite, updating the addressed register at that posedge.
- Read: prdata is registered at the setup phase (psel&!penable&!pwrite) and holds its value otherwise.
- pslverr=1 only during an access phase to an unmapped address. Such a write is ignored; such a read returns 0.
- Reset values: shadow=0, active=0, pending=0, CTRL=RST_EN, cnt=0, prdata=0, pslverr=0.
  - With defaults, clk_en=all ones after reset, because ratio 0 means continuously enabled.
- Per-channel datapath: shadow[n], active[n], pending[n], cnt[n] (RATIO_W bits).
- Channel enabled (CTRL[n]=1):
  - clk_en[n] = (cnt[n]==active[n]), combinational from flops.
  - Terminal cycle (cnt==active): next cnt=0; if pending, active<=shadow and pending<=0.
  - Otherwise cnt increments.
  - ratio r gives period r+1, with one enable cycle per period.
- Channel disabled (CTRL[n]=0):
  - clk_en[n]=0 and cnt=0.
  - active<=shadow every cycle; pending<=0.
- Re-enable: the first pulse occurs active cycles after CTRL[n] rises (cnt starts at 0).
- RATIO write: shadow<=pwdata[RATIO_W-1:0]; pending<=1. Upper pwdata bits are ignored.
- Write on a terminal cycle: the terminal load uses the pre-write shadow. pending stays 1 after the write, so the new value applies at the next terminal cycle.
- Ratio 0: every cycle is terminal, so a pending update applies on the cycle after the write.
- Rewriting shadow while pending is set: only the last value is ever applied.
- CTRL write on a terminal cycle: the new enable is visible from the next cycle.
- Reset mid-period: all channels restart from cnt=0 with active=0.
- Latency: RATIO write to visible pad_biu_clkratio change is at most old_active+1 cycles.

Test Plan:
- Reset with defaults -> clk_en=4'b1111, pad_biu_clkratio=0, read CTRL=0x0000000F, STATUS=0.
- Write RATIO[1]=3 -> clk_en[1] pulses at the terminal cycle, then exactly every 4 cycles. STATUS[1]=1 until the load. pad_biu_clkratio[5:3]=3 after the load.
- Channel 2 at ratio 5, write RATIO[2]=1 at cnt=2 -> the current period completes at 6 cycles; the next periods are 2 cycles; no pulse gap is shorter than 2 or longer than 6.
- Write the ratio exactly on the terminal cycle (ratio 2 then 7) -> one further period of 3, then periods of 8. Two back-to-back writes (4 then 6) -> only 6 is applied.
- Write CTRL=0x5 -> clk_en[1] and clk_en[3] are held 0. Write RATIO[3]=2 while disabled -> active updates the next cycle. Re-enable -> first clk_en[3] pulse 2 cycles after CTRL rises.
- Read/write 0x20 (NUM_CH=4) -> pslverr=1, prdata=0, no register changes. Assert clkrst mid-period -> all counters and ratios return to reset values on the next edge.
